// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, memory wait, redirect and trap flushing.
// State is registered; stall/flush outputs are decoded combinationally from state and live inputs.
module pipeline_ctrl #(
    parameter int unsigned LOAD_STALL_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dec_valid,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic        dec_uses_rs1,
    input  logic        dec_uses_rs2,
    input  logic        ex_valid,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_rd,
    input  logic        ex_redirect,
    input  logic        mem_busy,
    input  logic        wb_exception_valid,
    input  logic        trap_done,
    output logic        stall_fetch,
    output logic        stall_decode,
    output logic        stall_execute,
    output logic        flush_fetch,
    output logic        flush_decode,
    output logic        flush_execute,
    output logic [1:0]  state,
    output logic [15:0] bubble_count
);

    localparam logic [1:0] StRun       = 2'd0;
    localparam logic [1:0] StLoadStall = 2'd1;
    localparam logic [1:0] StMemWait   = 2'd2;
    localparam logic [1:0] StTrap      = 2'd3;

    // Extra bubbles owed after the first one issued from RUN.
    localparam logic [1:0] CntInit = 2'(LOAD_STALL_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] bubble_q;
    logic        bubble_inc;
    logic        rs1_match, rs2_match, hazard;

    assign rs1_match = dec_uses_rs1 && (dec_rs1 == ex_rd);
    assign rs2_match = dec_uses_rs2 && (dec_rs2 == ex_rd);
    assign hazard    = dec_valid && ex_valid && ex_is_load && (ex_rd != 5'd0)
                       && (rs1_match || rs2_match);

    always_comb begin
        stall_fetch   = 1'b0;
        stall_decode  = 1'b0;
        stall_execute = 1'b0;
        flush_fetch   = 1'b0;
        flush_decode  = 1'b0;
        flush_execute = 1'b0;
        bubble_inc    = 1'b0;
        state_d       = state_q;
        cnt_d         = cnt_q;

        if (wb_exception_valid) begin
            flush_fetch   = 1'b1;
            flush_decode  = 1'b1;
            flush_execute = 1'b1;
            state_d       = StTrap;
            cnt_d         = 2'd0;
        end else if (state_q == StTrap) begin
            flush_fetch   = 1'b1;
            flush_decode  = 1'b1;
            flush_execute = 1'b1;
            stall_fetch   = !trap_done;
            if (trap_done) begin
                state_d = StRun;
            end
        end else if (mem_busy) begin
            stall_fetch   = 1'b1;
            stall_decode  = 1'b1;
            stall_execute = 1'b1;
            state_d       = StMemWait;
            cnt_d         = 2'd0;
        end else if (ex_redirect) begin
            flush_fetch  = 1'b1;
            flush_decode = 1'b1;
            state_d      = StRun;
            cnt_d        = 2'd0;
        end else if (state_q == StLoadStall) begin
            // Hazard is not re-checked here; the load result is still in flight.
            stall_fetch  = 1'b1;
            flush_decode = 1'b1;
            bubble_inc   = 1'b1;
            cnt_d        = cnt_q - 2'd1;
            if (cnt_q == 2'd1) begin
                state_d = StRun;
            end
        end else begin
            // RUN, or MEM_WAIT on the first cycle memory is ready again.
            state_d = StRun;
            if (hazard) begin
                stall_fetch  = 1'b1;
                flush_decode = 1'b1;
                bubble_inc   = 1'b1;
                if (LOAD_STALL_CYCLES > 1) begin
                    state_d = StLoadStall;
                    cnt_d   = CntInit;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StRun;
            cnt_q    <= 2'd0;
            bubble_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (bubble_inc && (bubble_q != 16'hFFFF)) begin
                bubble_q <= bubble_q + 16'd1;
            end
        end
    end

    assign state        = state_q;
    assign bubble_count = bubble_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a mode-based reference model predicts each cycle's
// outputs into a queue; a monitor pops and compares them mid-cycle.
module tb_pipeline_ctrl;

    localparam int unsigned LSC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        dec_valid, dec_uses_rs1, dec_uses_rs2;
    logic [4:0]  dec_rs1, dec_rs2, ex_rd;
    logic        ex_valid, ex_is_load, ex_redirect, mem_busy;
    logic        wb_exception_valid, trap_done;
    logic        stall_fetch, stall_decode, stall_execute;
    logic        flush_fetch, flush_decode, flush_execute;
    logic [1:0]  state;
    logic [15:0] bubble_count;

    pipeline_ctrl #(.LOAD_STALL_CYCLES(LSC)) dut (
        .clk                (clk),
        .reset              (reset),
        .dec_valid          (dec_valid),
        .dec_rs1            (dec_rs1),
        .dec_rs2            (dec_rs2),
        .dec_uses_rs1       (dec_uses_rs1),
        .dec_uses_rs2       (dec_uses_rs2),
        .ex_valid           (ex_valid),
        .ex_is_load         (ex_is_load),
        .ex_rd              (ex_rd),
        .ex_redirect        (ex_redirect),
        .mem_busy           (mem_busy),
        .wb_exception_valid (wb_exception_valid),
        .trap_done          (trap_done),
        .stall_fetch        (stall_fetch),
        .stall_decode       (stall_decode),
        .stall_execute      (stall_execute),
        .flush_fetch        (flush_fetch),
        .flush_decode       (flush_decode),
        .flush_execute      (flush_execute),
        .state              (state),
        .bubble_count       (bubble_count)
    );

    always #5 clk = ~clk;

    // Reference model: which mode the controller is in, and how many bubbles are still owed.
    bit        m_trap, m_memwait;
    int        m_owed;
    int        m_bubbles;
    int        tests = 0, fails = 0, cyc = 0;
    logic [23:0] exp_q[$];
    string       tag_q[$];
    string       cur_tag = "reset";

    task automatic clear_inputs();
        reset = 0; dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_uses_rs1 = 0;
        dec_uses_rs2 = 0; ex_valid = 0; ex_is_load = 0; ex_rd = 0; ex_redirect = 0;
        mem_busy = 0; wb_exception_valid = 0; trap_done = 0;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        dec_valid = 1; dec_rs2 = rd; dec_uses_rs2 = 1; dec_rs1 = 5'd31; dec_uses_rs1 = 0;
        ex_valid = 1; ex_is_load = 1; ex_rd = rd;
    endtask

    // Predict this cycle's outputs from current inputs, queue them, advance the model one edge.
    task automatic cycle();
        bit hz, sf, sd, se, ff, fd, fe, bub;
        logic [1:0] st;
        hz = dec_valid && ex_valid && ex_is_load && (ex_rd != 0) &&
             ((dec_uses_rs1 && dec_rs1 == ex_rd) || (dec_uses_rs2 && dec_rs2 == ex_rd));
        st = m_trap ? 2'd3 : (m_memwait ? 2'd2 : (m_owed > 0 ? 2'd1 : 2'd0));
        {sf, sd, se, ff, fd, fe, bub} = '0;
        if (wb_exception_valid) begin
            {ff, fd, fe} = 3'b111;
            m_trap = 1; m_memwait = 0; m_owed = 0;
        end else if (m_trap) begin
            {ff, fd, fe} = 3'b111;
            sf = !trap_done;
            if (trap_done) m_trap = 0;
        end else if (mem_busy) begin
            {sf, sd, se} = 3'b111;
            m_memwait = 1; m_owed = 0;
        end else begin
            m_memwait = 0;
            if (ex_redirect) begin
                ff = 1; fd = 1; m_owed = 0;
            end else if (m_owed > 0) begin
                sf = 1; fd = 1; bub = 1; m_owed--;
            end else if (hz) begin
                sf = 1; fd = 1; bub = 1; m_owed = LSC - 1;
            end
        end
        exp_q.push_back({sf, sd, se, ff, fd, fe, st, 16'(m_bubbles)});
        tag_q.push_back(cur_tag);
        if (bub && m_bubbles < 65535) m_bubbles++;
        if (reset) begin
            m_trap = 0; m_memwait = 0; m_owed = 0; m_bubbles = 0;
        end
        @(negedge clk);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin : monitor
        logic [23:0] exp_v, act_v;
        string t;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                t = tag_q.pop_front();
                act_v = {stall_fetch, stall_decode, stall_execute, flush_fetch, flush_decode,
                         flush_execute, state, bubble_count};
                tests++;
                if (act_v !== exp_v) begin
                    fails++;
                    $display("FAIL %s cycle %0d: got st/fl=%b state=%0d bub=%0h, want st/fl=%b state=%0d bub=%0h",
                             t, cyc, act_v[23:18], act_v[17:16], act_v[15:0],
                             exp_v[23:18], exp_v[17:16], exp_v[15:0]);
                end
            end
            cyc++;
        end
    end

    initial begin
        clear_inputs();
        reset = 1;
        @(negedge clk);
        cycles(2);
        reset = 0;

        cur_tag = "idle_after_reset";
        cycles(3);

        cur_tag = "load_use_two_bubbles";
        set_load_use(5'd5);
        cycle();
        clear_inputs();
        cycles(3);

        cur_tag = "hazard_rd_zero";
        set_load_use(5'd0);
        cycles(2);
        clear_inputs();

        cur_tag = "hazard_with_redirect";
        set_load_use(5'd7);
        ex_redirect = 1;
        cycle();
        clear_inputs();
        cycles(2);

        cur_tag = "mem_busy_in_load_stall";
        set_load_use(5'd9);
        cycle();
        mem_busy = 1;
        cycles(3);
        mem_busy = 0;
        cycles(3);
        clear_inputs();
        cycles(1);

        cur_tag = "exception_then_trap";
        wb_exception_valid = 1; mem_busy = 1;
        cycle();
        wb_exception_valid = 0;
        cycles(4);
        trap_done = 1;
        cycle();
        clear_inputs();
        cycles(2);

        cur_tag = "bubble_saturation";
        force dut.bubble_q = 16'hFFFE;
        m_bubbles = 65534;
        #1;
        release dut.bubble_q;
        set_load_use(5'd3);
        cycles(2);
        clear_inputs();
        set_load_use(5'd4);
        cycles(2);
        clear_inputs();
        cycles(1);

        cur_tag = "reset_in_load_stall";
        set_load_use(5'd6);
        cycle();
        clear_inputs();
        reset = 1;
        cycle();
        reset = 0;
        cycles(2);

        cur_tag = "reset_in_trap";
        wb_exception_valid = 1;
        cycle();
        wb_exception_valid = 0;
        cycle();
        reset = 1;
        cycle();
        reset = 0;
        cycles(2);

        cur_tag = "random";
        for (int i = 0; i < 3000; i++) begin
            reset              = ($urandom_range(0, 99) == 0);
            dec_valid          = ($urandom_range(0, 9) < 8);
            dec_rs1            = 5'($urandom_range(0, 3));
            dec_rs2            = 5'($urandom_range(0, 3));
            dec_uses_rs1       = $urandom_range(0, 1) == 1;
            dec_uses_rs2       = $urandom_range(0, 1) == 1;
            ex_valid           = ($urandom_range(0, 9) < 8);
            ex_is_load         = ($urandom_range(0, 9) < 6);
            ex_rd              = 5'($urandom_range(0, 3));
            ex_redirect        = ($urandom_range(0, 9) == 0);
            mem_busy           = ($urandom_range(0, 5) == 0);
            wb_exception_valid = ($urandom_range(0, 29) == 0);
            trap_done          = ($urandom_range(0, 2) == 0);
            cycle();
        end
        clear_inputs();
        cycles(2);

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
